// File: rtl/dma_stream_scheduler.sv
// Round-robin descriptor scheduler: cores -> registered descriptor queue -> backend streams,
// with per-stream in-order tracking FIFOs that turn stream completions into per-core events.
module dma_stream_scheduler #(
  parameter int NB_CORES        = 4,
  parameter int NUM_STREAMS     = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int LEN_WIDTH       = 32,
  parameter int TID_WIDTH       = 16,
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NB_CORES-1:0]              core_valid_i,
  output logic [NB_CORES-1:0]              core_ready_o,
  input  logic [NB_CORES*ADDR_WIDTH-1:0]   core_src_i,
  input  logic [NB_CORES*ADDR_WIDTH-1:0]   core_dst_i,
  input  logic [NB_CORES*LEN_WIDTH-1:0]    core_len_i,
  output logic [TID_WIDTH-1:0]             core_tid_o,
  output logic [NUM_STREAMS-1:0]           stream_valid_o,
  input  logic [NUM_STREAMS-1:0]           stream_ready_i,
  output logic [ADDR_WIDTH-1:0]            stream_src_o,
  output logic [ADDR_WIDTH-1:0]            stream_dst_o,
  output logic [LEN_WIDTH-1:0]             stream_len_o,
  input  logic [NUM_STREAMS-1:0]           stream_done_i,
  output logic [NB_CORES-1:0]              term_event_o,
  output logic [TID_WIDTH-1:0]             completed_cnt_o,
  output logic                             busy_o,
  output logic                             error_o
);

  localparam int CW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
  localparam int SW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  function automatic logic [TW-1:0] trk_inc(input logic [TW-1:0] ptr);
    return (ptr == TW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
  endfunction

  logic [ADDR_WIDTH-1:0] q_src  [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_dst  [QUEUE_DEPTH];
  logic [LEN_WIDTH-1:0]  q_len  [QUEUE_DEPTH];
  logic [CW-1:0]         q_core [QUEUE_DEPTH];
  logic [QW-1:0]         q_wr, q_rd;
  logic [QW:0]           q_cnt;
  logic                  q_empty, q_full;

  logic [CW-1:0]         core_ptr, win_idx;
  logic [SW-1:0]         str_ptr, str_idx;
  logic                  win_found, str_found;
  logic [TID_WIDTH-1:0]  tid;

  logic [CW-1:0]         trk_mem [NUM_STREAMS][MAX_OUTSTANDING];
  logic [TW-1:0]         trk_wr  [NUM_STREAMS];
  logic [TW-1:0]         trk_rd  [NUM_STREAMS];
  logic [OW-1:0]         trk_cnt [NUM_STREAMS];

  logic                  push, pop, disp, zero_len;
  logic [NUM_STREAMS-1:0] eligible, trk_pop, stray;
  logic [NB_CORES-1:0]   term_nxt;
  logic [TID_WIDTH-1:0]  done_num;
  logic                  any_out;

  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == (QW+1)'(QUEUE_DEPTH));

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (!win_found && core_valid_i[(int'(core_ptr) + i) % NB_CORES]) begin
        win_found = 1'b1;
        win_idx   = CW'((int'(core_ptr) + i) % NB_CORES);
      end
    end
  end

  // Head of queue: zero-length descriptors retire in place, others go to a stream
  always_comb begin
    zero_len  = !q_empty && (q_len[q_rd] == '0);
    str_found = 1'b0;
    str_idx   = '0;
    for (int s = 0; s < NUM_STREAMS; s++)
      eligible[s] = stream_ready_i[s] && (trk_cnt[s] < OW'(MAX_OUTSTANDING));
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (!str_found && eligible[(int'(str_ptr) + i) % NUM_STREAMS]) begin
        str_found = 1'b1;
        str_idx   = SW'((int'(str_ptr) + i) % NUM_STREAMS);
      end
    end
    disp = !q_empty && !zero_len && str_found;
    pop  = disp || zero_len;
    push = win_found && (!q_full || pop);
  end

  assign stream_valid_o = disp ? (NUM_STREAMS'(1) << str_idx) : '0;
  assign core_ready_o   = push ? (NB_CORES'(1) << win_idx) : '0;
  assign core_tid_o     = tid;
  assign stream_src_o   = q_empty ? '0 : q_src[q_rd];
  assign stream_dst_o   = q_empty ? '0 : q_dst[q_rd];
  assign stream_len_o   = q_empty ? '0 : q_len[q_rd];

  always_comb begin
    term_nxt = '0;
    done_num = '0;
    any_out  = 1'b0;
    for (int s = 0; s < NUM_STREAMS; s++) begin
      trk_pop[s] = stream_done_i[s] && (trk_cnt[s] != '0);
      stray[s]   = stream_done_i[s] && (trk_cnt[s] == '0);
      any_out    = any_out || (trk_cnt[s] != '0);
      if (trk_pop[s]) begin
        term_nxt[trk_mem[s][trk_rd[s]]] = 1'b1;
        done_num = done_num + 1'b1;
      end
    end
    if (zero_len) begin
      term_nxt[q_core[q_rd]] = 1'b1;
      done_num = done_num + 1'b1;
    end
  end

  assign busy_o = !q_empty || any_out;

  // Control state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_wr            <= '0;
      q_rd            <= '0;
      q_cnt           <= '0;
      core_ptr        <= '0;
      str_ptr         <= '0;
      tid             <= '0;
      term_event_o    <= '0;
      completed_cnt_o <= '0;
      error_o         <= 1'b0;
      for (int s = 0; s < NUM_STREAMS; s++) begin
        trk_wr[s]  <= '0;
        trk_rd[s]  <= '0;
        trk_cnt[s] <= '0;
      end
    end else begin
      if (push) begin
        q_wr     <= q_wr + 1'b1;
        core_ptr <= CW'((int'(win_idx) + 1) % NB_CORES);
        tid      <= tid + 1'b1;
      end
      if (pop)
        q_rd <= q_rd + 1'b1;
      if (push && !pop)
        q_cnt <= q_cnt + 1'b1;
      else if (!push && pop)
        q_cnt <= q_cnt - 1'b1;
      if (disp)
        str_ptr <= SW'((int'(str_idx) + 1) % NUM_STREAMS);
      for (int s = 0; s < NUM_STREAMS; s++) begin
        if (stream_valid_o[s])
          trk_wr[s] <= trk_inc(trk_wr[s]);
        if (trk_pop[s])
          trk_rd[s] <= trk_inc(trk_rd[s]);
        if (stream_valid_o[s] && !trk_pop[s])
          trk_cnt[s] <= trk_cnt[s] + 1'b1;
        else if (!stream_valid_o[s] && trk_pop[s])
          trk_cnt[s] <= trk_cnt[s] - 1'b1;
      end
      term_event_o    <= term_nxt;
      completed_cnt_o <= completed_cnt_o + done_num;
      if (|stray)
        error_o <= 1'b1;
    end
  end

  // Descriptor and tracking storage
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_src[q_wr]  <= core_src_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      q_dst[q_wr]  <= core_dst_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      q_len[q_wr]  <= core_len_i[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
      q_core[q_wr] <= win_idx;
    end
    for (int s = 0; s < NUM_STREAMS; s++)
      if (stream_valid_o[s])
        trk_mem[s][trk_wr[s]] <= q_core[q_rd];
  end

endmodule

// File: tb/tb_dma_stream_scheduler.sv
// Directed bench for dma_stream_scheduler: arbitration, dispatch, completion, len==0, errors, reset.
module tb_dma_stream_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   core_valid = '0;
  logic [3:0]   core_ready;
  logic [255:0] core_src = '0;
  logic [255:0] core_dst = '0;
  logic [127:0] core_len = '0;
  logic [15:0]  core_tid;
  logic [3:0]   stream_valid;
  logic [3:0]   stream_ready = '0;
  logic [63:0]  stream_src, stream_dst;
  logic [31:0]  stream_len;
  logic [3:0]   stream_done = '0;
  logic [3:0]   term_event;
  logic [15:0]  completed_cnt;
  logic         busy, error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dma_stream_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_valid_i(core_valid), .core_ready_o(core_ready),
    .core_src_i(core_src), .core_dst_i(core_dst), .core_len_i(core_len),
    .core_tid_o(core_tid),
    .stream_valid_o(stream_valid), .stream_ready_i(stream_ready),
    .stream_src_o(stream_src), .stream_dst_o(stream_dst), .stream_len_o(stream_len),
    .stream_done_i(stream_done),
    .term_event_o(term_event), .completed_cnt_o(completed_cnt),
    .busy_o(busy), .error_o(error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    core_valid = '0; stream_ready = '0; stream_done = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // One descriptor from core_oh into an otherwise idle queue, then offer it with ready rdy.
  task automatic push1(input logic [3:0] core_oh, input logic [3:0] rdy, input logic [3:0] exp_sv);
    core_valid = core_oh; stream_ready = '0;
    #1;
    chk("push_ready", core_ready, core_oh);
    step();
    core_valid = '0; stream_ready = rdy;
    #1;
    chk("dispatch", stream_valid, exp_sv);
    step();
    stream_ready = '0;
  endtask

  task automatic set_default_desc();
    for (int c = 0; c < 4; c++) begin
      core_src[c*64 +: 64] = 64'hA000 + 64'(c);
      core_dst[c*64 +: 64] = 64'hB000 + 64'(c);
      core_len[c*32 +: 32] = 32'(16 * (c + 1));
    end
  endtask

  initial begin
    // Reset values
    step(); step();
    chk("rst_core_ready", core_ready, 0);
    chk("rst_stream_valid", stream_valid, 0);
    chk("rst_term", term_event, 0);
    chk("rst_completed", completed_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_tid", core_tid, 0);
    chk("rst_src", stream_src, 0);
    rst_n = 1'b1;

    // Single transfer end to end
    core_src[63:0] = 64'h1000; core_dst[63:0] = 64'h1000_0000; core_len[31:0] = 32'd64;
    stream_ready = 4'b1111; core_valid = 4'b0001;
    #1;
    chk("t1_ready", core_ready, 4'b0001);
    chk("t1_tid", core_tid, 0);
    step();
    core_valid = '0;
    #1;
    chk("t1_valid", stream_valid, 4'b0001);
    chk("t1_src", stream_src, 64'h1000);
    chk("t1_dst", stream_dst, 64'h1000_0000);
    chk("t1_len", stream_len, 64);
    step();
    chk("t1_valid_off", stream_valid, 0);
    chk("t1_busy_inflight", busy, 1);
    stream_done = 4'b0001;
    step();
    stream_done = '0;
    chk("t1_term", term_event, 4'b0001);
    chk("t1_completed", completed_cnt, 1);
    chk("t1_busy_idle", busy, 0);
    step();
    chk("t1_term_off", term_event, 0);

    // Core round-robin and full queue
    do_reset();
    set_default_desc();
    core_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_grant", core_ready, 4'b0001 << i);
      chk("t2_tid", core_tid, 16'(i));
      step();
    end
    #1;
    chk("t2_full_ready", core_ready, 0);
    chk("t2_full_busy", busy, 1);
    stream_ready = 4'b0001;
    #1;
    chk("t2_pushpop_ready", core_ready, 4'b0001);
    chk("t2_pushpop_tid", core_tid, 4);
    chk("t2_pushpop_valid", stream_valid, 4'b0001);
    chk("t2_pushpop_src", stream_src, 64'hA000);
    step();
    core_valid = '0; stream_ready = '0;
    #1;
    chk("t2_next_src", stream_src, 64'hA001);
    chk("t2_next_len", stream_len, 32);

    // Stream round-robin over 8 descriptors, then full-stream skip
    do_reset();
    stream_ready = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      core_valid = (i < 8) ? 4'b0001 : 4'b0000;
      #1;
      if (i < 8) chk("t3_push", core_ready, 4'b0001);
      if (i > 0) chk("t3_stream", stream_valid, 4'b0001 << ((i - 1) % 4));
      step();
    end
    core_valid = '0;
    push1(4'b0001, 4'b0001, 4'b0001);
    push1(4'b0001, 4'b1001, 4'b1000);
    push1(4'b0001, 4'b1111, 4'b0010);

    // Simultaneous completions for core 3
    do_reset();
    push1(4'b1000, 4'b0110, 4'b0010);
    push1(4'b1000, 4'b0110, 4'b0100);
    stream_done = 4'b0110;
    step();
    stream_done = '0;
    chk("t4_term", term_event, 4'b1000);
    chk("t4_completed", completed_cnt, 2);
    chk("t4_busy", busy, 0);
    step();
    chk("t4_term_single", term_event, 0);

    // Zero-length descriptor and stray done
    core_len[95:64] = '0;
    push1(4'b0100, 4'b1111, 4'b0000);
    chk("t5_term", term_event, 4'b0100);
    chk("t5_completed", completed_cnt, 3);
    chk("t5_busy", busy, 0);
    chk("t5_no_error", error, 0);
    stream_done = 4'b1000;
    step();
    stream_done = '0;
    chk("t5_error", error, 1);
    chk("t5_stray_term", term_event, 0);
    chk("t5_stray_cnt", completed_cnt, 3);
    step();
    chk("t5_error_sticky", error, 1);

    // Reset with 2 queued and 3 in flight
    core_len[95:64] = 32'd48;
    push1(4'b0001, 4'b1111, 4'b1000);
    push1(4'b0001, 4'b1111, 4'b0001);
    push1(4'b0001, 4'b1111, 4'b0010);
    push1(4'b0001, 4'b0000, 4'b0000);
    push1(4'b0001, 4'b0000, 4'b0000);
    chk("t6_busy_before", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_in_rst", busy, 0);
    chk("t6_error_cleared", error, 0);
    chk("t6_cnt_cleared", completed_cnt, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_busy_after", busy, 0);
    core_valid = 4'b0001;
    #1;
    chk("t6_ready", core_ready, 4'b0001);
    chk("t6_tid_restart", core_tid, 0);
    step();
    core_valid = '0;
    stream_done = 4'b0010;
    step();
    stream_done = '0;
    chk("t6_late_done_error", error, 1);
    chk("t6_queued_busy", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
